// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - time-multiplexed seven-segment hex scan driver
//
// Drives DIGITS seven-segment positions from one shared segment bus.
// A packed nibble vector is staged on load_i and copied into the displayed
// shadow copy only at the frame wrap, so a frame never shows a torn value.
// Digits are scanned one slot of CLK_DIV clocks at a time. The first cycle of
// every slot keeps all anodes off so the previous digit does not ghost.
//
// Optional feature macro: HEX_BRIGHTNESS_EN
//   When defined, adds bright_i. The lit anode is then held only while
//   prescaler < (bright_i+1)*(CLK_DIV/8) within each slot.
//
// Ports:
//   clk_50m      in   1         system clock
//   rst_n        in   1         asynchronous reset, active low
//   value_i      in   4*DIGITS  packed nibbles; nibble i = digit i, digit 0 rightmost
//   load_i       in   1         strobe: stage value_i for display
//   digit_en_i   in   DIGITS    1 = digit may light, 0 = forced dark (live)
//   blank_lz_i   in   1         1 = blank leading zeros (live)
//   bright_i     in   3         duty select, HEX_BRIGHTNESS_EN only (live)
//   hex_o        out  7         segments gfedcba, active low, registered
//   hex_on_o     out  DIGITS    digit enables, active low, one-hot-low, registered
//   frame_done_o out  1         one-cycle pulse in the cycle after a wrap tick
module hex_scan_driver #(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 50000
) (
  input  logic                clk_50m,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value_i,
  input  logic                load_i,
  input  logic [DIGITS-1:0]   digit_en_i,
  input  logic                blank_lz_i,
`ifdef HEX_BRIGHTNESS_EN
  input  logic [2:0]          bright_i,
`endif
  output logic [6:0]          hex_o,
  output logic [DIGITS-1:0]   hex_on_o,
  output logic                frame_done_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]       prescaler;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] staged;
  logic [4*DIGITS-1:0] shadow;
  logic                pending;

  logic                tick;
  logic                wrap;

  logic [DIGITS-1:0]   upper_zero;
  logic [3:0]          cur_nib;
  logic                digit_dark;
  logic                slot_dead;
  logic                duty_ok;
  logic [6:0]          hex_d;
  logic [DIGITS-1:0]   hex_on_d;

  // Segment pattern for one nibble, gfedcba active low.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot timing: tick ends a slot, wrap ends the last slot of a frame.
  assign tick = (prescaler == PS_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // With DIGITS=1 idx stays 0 and every tick is a wrap.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      if (idx == IDX_LAST) begin
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Staging and shadow. A load that lands on the wrap tick bypasses the
  // staging register so it is shown in the frame starting right away;
  // pending is cleared because nothing newer is waiting.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      staged  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (load_i && wrap) begin
        staged  <= value_i;
        shadow  <= value_i;
        pending <= 1'b0;
      end else if (load_i) begin
        staged  <= value_i;
        pending <= 1'b1;
      end else if (wrap && pending) begin
        shadow  <= staged;
        pending <= 1'b0;
      end
    end
  end

  // upper_zero[d] = nibbles d..DIGITS-1 of the shadow are all zero.
  always_comb begin
    logic run_zero;
    run_zero   = 1'b1;
    upper_zero = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      run_zero      = run_zero && (shadow[4*d +: 4] == 4'h0);
      upper_zero[d] = run_zero;
    end
  end

  // Next output word for the digit currently addressed by idx.
  always_comb begin
    cur_nib    = shadow[{idx, 2'b00} +: 4];
    // Digit 0 is never lead-blanked so a zero value still shows "0".
    digit_dark = !digit_en_i[idx] ||
                 (blank_lz_i && (idx != '0) && upper_zero[idx]);
    slot_dead  = (prescaler == '0);
`ifdef HEX_BRIGHTNESS_EN
    duty_ok    = (int'(prescaler) < ((int'(bright_i) + 1) * (CLK_DIV / 8)));
`else
    duty_ok    = 1'b1;
`endif
    hex_d      = digit_dark ? 7'h7F : seg7(cur_nib);
    // The dead cycle only turns the anode off; the segment bus already
    // carries the new digit so it is settled when the anode comes on.
    if (!digit_dark && !slot_dead && duty_ok) begin
      hex_on_d = ~(DIGITS'(1) << idx);
    end else begin
      hex_on_d = '1;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      hex_o        <= 7'h7F;
      hex_on_o     <= '1;
      frame_done_o <= 1'b0;
    end else begin
      hex_o        <= hex_d;
      hex_on_o     <= hex_on_d;
      frame_done_o <= wrap;
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// tb/tb_hex_scan_driver.sv - scoreboard bench for hex_scan_driver
module tb_hex_scan_driver;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic [6:0]  hex;
  logic [3:0]  hex_on;
  logic        frame_done;
`ifdef HEX_BRIGHTNESS_EN
  logic [2:0]  bright = 3'd7;
`endif

  always #5 clk = ~clk;

  hex_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
    .clk_50m      (clk),
    .rst_n        (rst_n),
    .value_i      (value),
    .load_i       (load),
    .digit_en_i   (digit_en),
    .blank_lz_i   (blank_lz),
`ifdef HEX_BRIGHTNESS_EN
    .bright_i     (bright),
`endif
    .hex_o        (hex),
    .hex_on_o     (hex_on),
    .frame_done_o (frame_done)
  );

  typedef struct packed {
    logic [3:0] on;
    logic [6:0] seg;
    logic [7:0] len;
  } burst_t;

  burst_t exp_q[$];
  int     n_check = 0;
  int     n_pass  = 0;
  logic   mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_check++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic push(input logic [3:0] on, input logic [6:0] seg);
    burst_t e;
    e.on  = on;
    e.seg = seg;
    e.len = 8'd7;
    exp_q.push_back(e);
  endtask

  // Monitor: a burst is a run of identical lit output words; each finished
  // burst is compared against the next expected entry.
  logic [3:0] cur_on;
  logic [6:0] cur_seg;
  int         cur_len;
  logic       open_b;

  task automatic close_burst();
    burst_t e;
    n_check++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_burst: got on=%h seg=%h len=%0d, expected no burst",
               cur_on, cur_seg, cur_len);
    end else begin
      e = exp_q.pop_front();
      if (cur_on === e.on && cur_seg === e.seg && cur_len == int'(e.len)) n_pass++;
      else $display("FAIL burst: got on=%h seg=%h len=%0d, expected on=%h seg=%h len=%0d",
                    cur_on, cur_seg, cur_len, e.on, e.seg, e.len);
    end
  endtask

  initial begin
    open_b = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        open_b = 1'b0;
      end else begin
        if (open_b && (hex_on == 4'hF || hex_on != cur_on || hex != cur_seg)) begin
          if (mon_en) close_burst();
          open_b = 1'b0;
        end
        if (!open_b && hex_on != 4'hF) begin
          open_b  = 1'b1;
          cur_on  = hex_on;
          cur_seg = hex;
          cur_len = 0;
        end
        if (open_b) cur_len++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic measure_latency();
    int n;
    n = 0;
    while (!frame_done && n < 100) begin
      step();
      n++;
    end
    chk("frame_done_latency", n, 32);
  endtask

  // Waits for the frame_done pulse, then moves two cycles on so the last
  // digit of the finished frame has left the output register.
  task automatic wait_frame();
    int n;
    n = 0;
    while (!frame_done && n < 100) begin
      step();
      n++;
    end
    if (!frame_done) begin
      n_check++;
      $display("FAIL frame_timeout: got no frame_done in %0d cycles, expected one", n);
    end
    step();
    step();
  endtask

  task automatic end_frame();
    wait_frame();
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    value    = 16'h0;
    load     = 1'b0;
    digit_en = 4'hF;
    blank_lz = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    measure_latency();

    // Mid-slot reset while digit 2 is lit (shadow 0 shows "0").
    repeat (20) step();
    chk("pre_reset_hex_on", hex_on, 4'hB);
    chk("pre_reset_hex", hex, 7'h40);
    rst_n = 1'b0;
    #1;
    chk("reset_hex_on", hex_on, 4'hF);
    chk("reset_hex", hex, 7'h7F);
    chk("reset_frame_done", frame_done, 1'b0);
    step();
    rst_n = 1'b1;
    measure_latency();

    // Frame 1: stage 12AF, not yet visible.
    step();
    step();
    pulse_load(16'h12AF);
    end_frame();

    // Frame 2: 12AF shown; 1111 then 2222 staged mid-frame.
    mon_en = 1'b1;
    push(4'hE, 7'h0E); push(4'hD, 7'h08); push(4'hB, 7'h24); push(4'h7, 7'h79);
    repeat (5) step();
    pulse_load(16'h1111);
    repeat (5) step();
    pulse_load(16'h2222);
    end_frame();

    // Frame 3: only 2222; 7777 staged, then 3456 loaded on the wrap tick.
    push(4'hE, 7'h24); push(4'hD, 7'h24); push(4'hB, 7'h24); push(4'h7, 7'h24);
    repeat (10) step();
    pulse_load(16'h7777);
    repeat (18) step();
    value = 16'h3456;
    load  = 1'b1;
    step();
    load  = 1'b0;
    end_frame();

    // Frame 4: 3456 shown immediately; enable blanking, stage 0050.
    push(4'hE, 7'h02); push(4'hD, 7'h12); push(4'hB, 7'h19); push(4'h7, 7'h30);
    blank_lz = 1'b1;
    repeat (5) step();
    pulse_load(16'h0050);
    end_frame();

    // Frame 5: digits 3,2 blanked; stage 0000.
    push(4'hE, 7'h40); push(4'hD, 7'h12);
    repeat (5) step();
    pulse_load(16'h0000);
    end_frame();

    // Frame 6: only digit 0 showing "0"; stage 12AF.
    push(4'hE, 7'h40);
    repeat (5) step();
    pulse_load(16'h12AF);
    end_frame();

    // Frame 7: digit 2 disabled, blanking off.
    blank_lz = 1'b0;
    digit_en = 4'b1011;
    push(4'hE, 7'h0E); push(4'hD, 7'h08); push(4'h7, 7'h79);
    end_frame();

    mon_en   = 1'b0;
    digit_en = 4'hF;
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
